branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution from EX. Classifies each resolved control-flow instruction as correct or mispredicted.
- Issues one registered PC redirect plus a multi-cycle front-end flush, and drops wrong-path resolutions during the flush.
- Queues BTB/BHT training updates into a small FIFO. The FIFO drains over a valid/ready port to the shared predictor write port.
- Sits between the EX stage and the fetch PC mux / BTB.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays high after a redirect (>=1)
UPD_DEPTH, 4, update FIFO entries (power of 2, >=2)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_valid  in  1  a branch/jump resolved in EX this cycle
ex_ready  out  1  controller can accept ex_valid this cycle
ex_taken  in  1  actual direction
ex_pred_taken  in  1  direction predicted at fetch
ex_pc  in  32  PC of the branch
ex_target  in  32  actual taken target
ex_pred_target  in  32  target predicted at fetch
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  32  corrected fetch PC
flush  out  1  squash IF/ID (and ID/EX) contents
upd_valid  out  1  FIFO head valid
upd_ready  in  1  predictor write port accepts the head
upd_pc  out  32  head: branch PC
upd_target  out  32  head: actual target
upd_taken  out  1  head: actual direction
mispred_cnt  out  CNT_W  saturating count of mispredictions
branch_cnt  out  CNT_W  saturating count of accepted resolutions

Behaviour:
- Reset: all outputs are 0, state is IDLE, FIFO is empty, counters are 0. A reset asserted mid-flush or with a non-empty FIFO discards everything the same cycle.
- States:
  - IDLE.
  - FLUSH, with a down-counter fl_cnt of width clog2(FLUSH_CYCLES+1).
- ex_ready:
  - IDLE: ex_ready = (fifo_count < UPD_DEPTH).
  - FLUSH: ex_ready = 1, and any ex_valid is dropped as wrong-path (no count, no enqueue).
- Accept = ex_valid & ex_ready & (state==IDLE). EX must hold its inputs stable while ex_valid & !ex_ready.
- Classification, combinational on accept:
  - pred NT, actual NT: correct.
  - pred NT, actual T: mispredict, target = ex_target.
  - pred T, actual NT: mispredict, target = ex_pc+4 (mod 2^32).
  - pred T, actual T, ex_pred_target==ex_target: correct.
  - pred T, actual T, targets differ: mispredict, target = ex_target.
- On accept:
  - branch_cnt increments.
  - The entry {ex_pc, ex_target, ex_taken} is enqueued, for correct predictions too.
- On an accepted mispredict:
  - Next cycle: redirect_valid=1 for exactly 1 cycle, with redirect_pc registered. flush=1 starting in that same cycle.
  - State becomes FLUSH with fl_cnt=FLUSH_CYCLES-1.
  - mispred_cnt increments.
- In FLUSH: flush=1. When fl_cnt==0 the state goes to IDLE next cycle, otherwise fl_cnt decrements. Flush is therefore high for exactly FLUSH_CYCLES consecutive cycles.
- redirect_pc holds its last value when redirect_valid=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- FIFO:
  - Dequeue when upd_valid & upd_ready; upd_* always show the head.
  - Enqueue and dequeue in the same cycle keep the count unchanged.
  - When full, ex_ready=0; there is no pass-through, even if upd_ready=1 that cycle.
  - Pointers wrap modulo UPD_DEPTH.
  - The FIFO keeps draining during FLUSH. Already-enqueued updates belong to committed branches and are never dropped by flush.
- Width rule: all PC arithmetic is 32-bit, and the carry out of ex_pc+4 is discarded.

Decomposition:
- Shared package:
  - State enum {IDLE, FLUSH}.
  - PC width constant (32).
  - Update-entry struct {pc, target, taken}.
- Sub-module upd_fifo: a parameterised synchronous FIFO with valid/ready on the read side, full/count outputs, and synchronous active-high reset.
- Classification and FSM stay in branch_resolve_ctrl.

Test Plan:
- Reset, then an accept with pred NT, taken, ex_pc=0x100, ex_target=0x200:
  - Next cycle: redirect_valid=1, redirect_pc=0x200, flush high 2 cycles.
  - mispred_cnt=1, branch_cnt=1.
  - FIFO head {0x100, 0x200, 1}.
- pred T, not taken, ex_pc=0xFFFFFFFC: redirect_pc=0x00000000 (wrap). A second ex_valid during the flush cycles is dropped: branch_cnt stays 1, nothing is enqueued.
- pred T, taken, ex_pred_target=0x300, ex_target=0x340: redirect_pc=0x340. With ex_pred_target=0x340 instead: no redirect, no flush, branch_cnt+1, one enqueue.
- upd_ready=0, with 4 correct-prediction accepts, then a 5th ex_valid:
  - ex_ready=0 and the 5th is held.
  - Raise upd_ready for 1 cycle: head pops, ex_ready=1, and the held branch is accepted and enqueued; entry order is preserved.
- Mid-flush with 3 FIFO entries, assert reset 1 cycle: flush=0, upd_valid=0, counters 0, state IDLE on the following cycle.
- Force branch_cnt to 0xFFFF via 65535+ accepts (or CNT_W=4 with 20 accepts): the counter holds at max and does not wrap.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller slice.
package branch_resolve_ctrl_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            taken;
  } upd_entry_t;

  // Fall-through PC; the carry out of bit 31 is discarded.
  function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// EX-side resolution, fetch redirect, predictor update and statistics bundle.
interface branch_resolve_ctrl_if
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic            ex_valid;
  logic            ex_ready;
  logic            ex_taken;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pc;
  logic [PC_W-1:0] ex_target;
  logic [PC_W-1:0] ex_pred_target;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;

  logic            upd_valid;
  logic            upd_ready;
  logic [PC_W-1:0] upd_pc;
  logic [PC_W-1:0] upd_target;
  logic            upd_taken;

  logic [CNT_W-1:0] mispred_cnt;
  logic [CNT_W-1:0] branch_cnt;

  modport slave (
    input  ex_valid, ex_taken, ex_pred_taken, ex_pc, ex_target, ex_pred_target,
    input  upd_ready,
    output ex_ready, redirect_valid, redirect_pc, flush,
    output upd_valid, upd_pc, upd_target, upd_taken,
    output mispred_cnt, branch_cnt
  );

  modport master (
    output ex_valid, ex_taken, ex_pred_taken, ex_pc, ex_target, ex_pred_target,
    output upd_ready,
    input  ex_ready, redirect_valid, redirect_pc, flush,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    input  mispred_cnt, branch_cnt
  );

endinterface

// File: rtl/branch_resolve_ctrl_upd_fifo.sv
// Synchronous FIFO for predictor training entries; valid/ready read side.
module upd_fifo
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  upd_entry_t    wr_data_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output upd_entry_t    rd_data_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  upd_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // No pass-through: a full FIFO refuses writes even while it is being read.
  assign push = wr_en_i & ~full_o;
  assign pop  = rd_valid_o & rd_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Classifies resolved branches, issues redirect + timed flush, queues predictor training.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned UPD_DEPTH    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_ctrl_if.slave bus
);

  localparam int unsigned FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned CW   = $clog2(UPD_DEPTH) + 1;

  state_e           state_q;
  logic [FL_W-1:0]  fl_cnt_q;
  logic             redirect_valid_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic             flush_q;
  logic [CNT_W-1:0] mispred_cnt_q;
  logic [CNT_W-1:0] branch_cnt_q;

  logic             fifo_full;
  logic [CW-1:0]    fifo_count;
  upd_entry_t       fifo_head;
  upd_entry_t       fifo_wr_data;
  logic             ex_ready;
  logic             accept;
  logic             mispred_d;
  logic [PC_W-1:0]  redirect_pc_d;

  assign ex_ready = (state_q == FLUSH) ? 1'b1 : (fifo_count < CW'(UPD_DEPTH));
  assign accept   = bus.ex_valid & ex_ready & (state_q == IDLE);

  always_comb begin
    mispred_d     = 1'b0;
    redirect_pc_d = bus.ex_target;
    case ({bus.ex_pred_taken, bus.ex_taken})
      2'b01: mispred_d = 1'b1;
      2'b10: begin
        mispred_d     = 1'b1;
        redirect_pc_d = seq_pc(bus.ex_pc);
      end
      2'b11:   mispred_d = (bus.ex_pred_target != bus.ex_target);
      default: mispred_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      fl_cnt_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && mispred_d) begin
            state_q          <= FLUSH;
            fl_cnt_q         <= FL_W'(FLUSH_CYCLES - 1);
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= 1'b1;
          end
        end
        FLUSH: begin
          if (fl_cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            fl_cnt_q <= fl_cnt_q - FL_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (accept && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (accept && mispred_d && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign fifo_wr_data = '{pc: bus.ex_pc, target: bus.ex_target, taken: bus.ex_taken};

  upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (accept & ~fifo_full),
    .wr_data_i  (fifo_wr_data),
    .rd_valid_o (bus.upd_valid),
    .rd_ready_i (bus.upd_ready),
    .rd_data_o  (fifo_head),
    .full_o     (fifo_full),
    .count_o    (fifo_count)
  );

  assign bus.ex_ready       = ex_ready;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.upd_pc         = fifo_head.pc;
  assign bus.upd_target     = fifo_head.target;
  assign bus.upd_taken      = fifo_head.taken;
  assign bus.mispred_cnt    = mispred_cnt_q;
  assign bus.branch_cnt     = branch_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl (FLUSH_CYCLES=2, UPD_DEPTH=4, CNT_W=4).
module tb_branch_resolve_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   nt = 0;
  int   nf = 0;

  branch_resolve_ctrl_if #(.CNT_W(4)) bus ();

  branch_resolve_ctrl #(
    .FLUSH_CYCLES (2),
    .UPD_DEPTH    (4),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic pt, input logic t,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] ptgt);
    bus.ex_valid       = v;
    bus.ex_pred_taken  = pt;
    bus.ex_taken       = t;
    bus.ex_pc          = pc;
    bus.ex_target      = tgt;
    bus.ex_pred_target = ptgt;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus.upd_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nt++; if (bus.redirect_valid !== 1'b0) begin nf++; $display("FAIL rst_redir got %b exp 0", bus.redirect_valid); end
    nt++; if (bus.redirect_pc !== 32'h0) begin nf++; $display("FAIL rst_redir_pc got %h exp 0", bus.redirect_pc); end
    nt++; if (bus.flush !== 1'b0) begin nf++; $display("FAIL rst_flush got %b exp 0", bus.flush); end
    nt++; if (bus.upd_valid !== 1'b0) begin nf++; $display("FAIL rst_upd_valid got %b exp 0", bus.upd_valid); end
    nt++; if (bus.branch_cnt !== 4'd0 || bus.mispred_cnt !== 4'd0) begin nf++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", bus.branch_cnt, bus.mispred_cnt); end
    nt++; if (bus.ex_ready !== 1'b1) begin nf++; $display("FAIL rst_ex_ready got %b exp 1", bus.ex_ready); end
  endtask

  task automatic test_mispred_nt_t();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    nt++; if (bus.redirect_valid !== 1'b1) begin nf++; $display("FAIL ntt_redir got %b exp 1", bus.redirect_valid); end
    nt++; if (bus.redirect_pc !== 32'h200) begin nf++; $display("FAIL ntt_redir_pc got %h exp 200", bus.redirect_pc); end
    nt++; if (bus.flush !== 1'b1) begin nf++; $display("FAIL ntt_flush1 got %b exp 1", bus.flush); end
    nt++; if (bus.mispred_cnt !== 4'd1 || bus.branch_cnt !== 4'd1) begin nf++; $display("FAIL ntt_cnt got %0d/%0d exp 1/1", bus.mispred_cnt, bus.branch_cnt); end
    nt++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h100 || bus.upd_target !== 32'h200 || bus.upd_taken !== 1'b1)
      begin nf++; $display("FAIL ntt_head got %b %h %h %b exp 1 100 200 1", bus.upd_valid, bus.upd_pc, bus.upd_target, bus.upd_taken); end
    tick();
    nt++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b1 || bus.redirect_pc !== 32'h200)
      begin nf++; $display("FAIL ntt_cyc2 got rv=%b fl=%b pc=%h exp 0 1 200", bus.redirect_valid, bus.flush, bus.redirect_pc); end
    tick();
    nt++; if (bus.flush !== 1'b0) begin nf++; $display("FAIL ntt_flush_end got %b exp 0", bus.flush); end
  endtask

  task automatic test_wrap_and_drop();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h500, 32'h500);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h700, 32'h800, 32'h0);
    nt++; if (bus.redirect_pc !== 32'h0 || bus.redirect_valid !== 1'b1) begin nf++; $display("FAIL wrap_pc got %h rv=%b exp 0 1", bus.redirect_pc, bus.redirect_valid); end
    nt++; if (bus.ex_ready !== 1'b1) begin nf++; $display("FAIL wrap_ready_flush got %b exp 1", bus.ex_ready); end
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    nt++; if (bus.branch_cnt !== 4'd1 || bus.mispred_cnt !== 4'd1) begin nf++; $display("FAIL drop_cnt got %0d/%0d exp 1/1", bus.branch_cnt, bus.mispred_cnt); end
    nt++; if (bus.upd_pc !== 32'hFFFF_FFFC || bus.upd_taken !== 1'b0 || bus.upd_target !== 32'h500)
      begin nf++; $display("FAIL drop_head got %h %h %b exp fffffffc 500 0", bus.upd_pc, bus.upd_target, bus.upd_taken); end
    bus.upd_ready = 1'b1;
    tick();
    bus.upd_ready = 1'b0;
    nt++; if (bus.upd_valid !== 1'b0) begin nf++; $display("FAIL drop_enq got %b exp 0", bus.upd_valid); end
  endtask

  task automatic test_target_mismatch();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'h400, 32'h340, 32'h300);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    nt++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h340) begin nf++; $display("FAIL tgt_redir got %b %h exp 1 340", bus.redirect_valid, bus.redirect_pc); end
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h404, 32'h340, 32'h340);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    nt++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin nf++; $display("FAIL tgt_match got rv=%b fl=%b exp 0 0", bus.redirect_valid, bus.flush); end
    nt++; if (bus.branch_cnt !== 4'd2 || bus.mispred_cnt !== 4'd1) begin nf++; $display("FAIL tgt_cnt got %0d/%0d exp 2/1", bus.branch_cnt, bus.mispred_cnt); end
    bus.upd_ready = 1'b1;
    tick();
    nt++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h404) begin nf++; $display("FAIL tgt_second got %b %h exp 1 404", bus.upd_valid, bus.upd_pc); end
    tick();
    bus.upd_ready = 1'b0;
    nt++; if (bus.upd_valid !== 1'b0) begin nf++; $display("FAIL tgt_empty got %b exp 0", bus.upd_valid); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h1004, 32'h1008, 32'h100C, 32'h2000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i * 4), 32'h1100 + 32'(i), 32'h0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h2000, 32'h2100, 32'h0);
    nt++; if (bus.ex_ready !== 1'b0) begin nf++; $display("FAIL full_ready got %b exp 0", bus.ex_ready); end
    tick();
    nt++; if (bus.branch_cnt !== 4'd4) begin nf++; $display("FAIL full_held got %0d exp 4", bus.branch_cnt); end
    bus.upd_ready = 1'b1;
    tick();
    bus.upd_ready = 1'b0;
    nt++; if (bus.ex_ready !== 1'b1 || bus.upd_pc !== 32'h1004) begin nf++; $display("FAIL full_pop got rdy=%b pc=%h exp 1 1004", bus.ex_ready, bus.upd_pc); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    nt++; if (bus.branch_cnt !== 4'd5 || bus.ex_ready !== 1'b0) begin nf++; $display("FAIL full_accept got cnt=%0d rdy=%b exp 5 0", bus.branch_cnt, bus.ex_ready); end
    bus.upd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nt++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== exp_pc[k]) begin nf++; $display("FAIL full_order%0d got %b %h exp 1 %h", k, bus.upd_valid, bus.upd_pc, exp_pc[k]); end
      tick();
    end
    bus.upd_ready = 1'b0;
    nt++; if (bus.upd_valid !== 1'b0) begin nf++; $display("FAIL full_drained got %b exp 0", bus.upd_valid); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h14, 32'h24, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h18, 32'h28, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    nt++; if (bus.flush !== 1'b1 || bus.branch_cnt !== 4'd3) begin nf++; $display("FAIL mid_pre got fl=%b cnt=%0d exp 1 3", bus.flush, bus.branch_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nt++; if (bus.flush !== 1'b0 || bus.upd_valid !== 1'b0 || bus.redirect_valid !== 1'b0)
      begin nf++; $display("FAIL mid_rst got fl=%b uv=%b rv=%b exp 0 0 0", bus.flush, bus.upd_valid, bus.redirect_valid); end
    nt++; if (bus.branch_cnt !== 4'd0 || bus.mispred_cnt !== 4'd0) begin nf++; $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", bus.branch_cnt, bus.mispred_cnt); end
    tick();
    nt++; if (bus.flush !== 1'b0 || bus.ex_ready !== 1'b1) begin nf++; $display("FAIL mid_idle got fl=%b rdy=%b exp 0 1", bus.flush, bus.ex_ready); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.upd_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h80, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    nt++; if (bus.branch_cnt !== 4'hF) begin nf++; $display("FAIL sat_branch got %0d exp 15", bus.branch_cnt); end
    // One mispredict is accepted per three cycles (accept + two flush cycles).
    drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h80, 32'h0);
    for (int i = 0; i < 60; i++) tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    nt++; if (bus.mispred_cnt !== 4'hF || bus.branch_cnt !== 4'hF) begin nf++; $display("FAIL sat_mispred got %0d/%0d exp 15/15", bus.mispred_cnt, bus.branch_cnt); end
    bus.upd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.upd_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    test_reset();
    test_mispred_nt_t();
    test_wrap_and_drop();
    test_target_mismatch();
    test_fifo_full();
    test_reset_mid_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
